// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard detection for the decode/issue stage. It
// searches a set of downstream stages, tracks long-latency writes and counts stalls.
module fwd_hazard_unit #(
    parameter int NSRC = 2,
    parameter int NSTG = 3,
    parameter int RAW  = 5,
    parameter int DW   = 32,
    parameter int CNTW = 2,
    parameter int WDOG = 64
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [NSRC*RAW-1:0]                   src_reg,
    input  logic [NSTG*RAW-1:0]                   stg_dst,
    input  logic [NSTG-1:0]                       stg_wen,
    input  logic [NSTG-1:0]                       stg_rdy,
    input  logic [NSTG*DW-1:0]                    stg_data,
    input  logic                                  iss_v,
    input  logic [RAW-1:0]                        iss_dst,
    output logic                                  iss_ready,
    input  logic                                  done_v,
    input  logic [RAW-1:0]                        done_dst,
    output logic [NSRC*$clog2(NSTG+1)-1:0]        fwd_sel,
    output logic [NSRC*DW-1:0]                    fwd_data,
    output logic                                  stall,
    output logic [31:0]                           stall_cnt,
    output logic                                  deadlock,
    output logic                                  sb_err
);

    localparam int SELW = $clog2(NSTG + 1);
    localparam int NREG = 2 ** RAW;
    localparam int WDW  = $clog2(WDOG + 1);
    localparam logic [CNTW-1:0] BUSY_MAX = '1;

    logic [CNTW-1:0] r_busy      [NREG];
    logic [CNTW-1:0] w_busy_next [NREG];
    logic [NSRC-1:0] w_op_hz;
    logic [NSRC-1:0] w_sb_hz;
    logic            w_done_same;
    logic            w_iss_inc;
    logic            w_done_dec;
    logic            w_sb_err_set;
    logic            w_stall;
    logic [31:0]     r_stall_cnt;
    logic [WDW-1:0]  r_wdog;
    logic            r_deadlock;
    logic            r_sb_err;

    genvar gi;

    // Per-operand resolution: the youngest matching stage wins, even when it is not ready.
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [RAW-1:0]  w_src;
            logic [SELW-1:0] w_sel;
            logic [DW-1:0]   w_data;
            logic            w_hz;
            logic            w_found;

            assign w_src = src_reg[gi*RAW +: RAW];

            always_comb begin
                w_sel   = '0;
                w_data  = '0;
                w_hz    = 1'b0;
                w_found = 1'b0;
                if (w_src != '0) begin
                    for (int i = 0; i < NSTG; i++) begin
                        if (!w_found && stg_wen[i] && (stg_dst[i*RAW +: RAW] == w_src)) begin
                            w_found = 1'b1;
                            if (stg_rdy[i]) begin
                                w_sel  = SELW'(i + 1);
                                w_data = stg_data[i*DW +: DW];
                            end else begin
                                w_hz = 1'b1;
                            end
                        end
                    end
                end
            end

            assign fwd_sel[gi*SELW +: SELW] = w_sel;
            assign fwd_data[gi*DW +: DW]    = w_data;
            assign w_op_hz[gi]              = w_hz;
            assign w_sb_hz[gi]              = (w_src != '0) && (r_busy[w_src] != '0);
        end
    endgenerate

    // A same-cycle writeback frees a slot, so a saturated counter can still accept an issue.
    assign w_done_same  = done_v && (done_dst == iss_dst);
    assign iss_ready    = !((r_busy[iss_dst] == BUSY_MAX) && !w_done_same);
    assign w_iss_inc    = iss_v && iss_ready && (iss_dst != '0);
    assign w_done_dec   = done_v && (done_dst != '0);
    assign w_sb_err_set = w_done_dec && (r_busy[done_dst] == '0)
                          && !(w_iss_inc && (iss_dst == done_dst));

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = '0;
            end else begin : g_reg
                logic w_inc;
                logic w_dec;
                assign w_inc = w_iss_inc && (iss_dst == RAW'(gi));
                assign w_dec = w_done_dec && (done_dst == RAW'(gi));
                assign w_busy_next[gi] =
                    (w_inc && !w_dec)                         ? r_busy[gi] + 1'b1 :
                    (w_dec && !w_inc && (r_busy[gi] != '0))   ? r_busy[gi] - 1'b1 :
                                                                r_busy[gi];
            end
        end
    endgenerate

    assign w_stall = (|w_op_hz) || (|w_sb_hz) || (iss_v && !iss_ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREG; r++) begin
                r_busy[r] <= '0;
            end
            r_stall_cnt <= '0;
            r_wdog      <= '0;
            r_deadlock  <= 1'b0;
            r_sb_err    <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_busy[r] <= w_busy_next[r];
            end
            if (w_sb_err_set) begin
                r_sb_err <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            // Watchdog counts consecutive stalls and saturates at its threshold.
            if (!w_stall) begin
                r_wdog <= '0;
            end else if (r_wdog != WDW'(WDOG)) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_stall && (r_wdog == WDW'(WDOG - 1))) begin
                r_deadlock <= 1'b1;
            end
        end
    end

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;
    assign deadlock  = r_deadlock;
    assign sb_err    = r_sb_err;

endmodule
